// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 sequencer: scheduler states, memory owner codes
// and default datapath widths.
package arc4_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int KEY_W_DEF  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHUF,
        ST_PRGA,
        ST_HANDOFF,
        ST_DONE,
        ST_ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INIT = 2'd1,
        OWN_SHUF = 2'd2,
        OWN_PRGA = 2'd3
    } owner_t;

    // Memory owner implied by a phase state; non-phase states own nothing.
    function automatic owner_t owner_of(input sched_state_t s);
        case (s)
            ST_INIT: return OWN_INIT;
            ST_SHUF: return OWN_SHUF;
            ST_PRGA: return OWN_PRGA;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_wdog.sv
// Per-phase watchdog: loadable up-counter that flags expiry on its last count.
module phase_wdog #(
    parameter int  TIMEOUT = 4096,
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init, key shuffle and PRGA in order on one
// shared S memory, owns the memory port and guards each phase with a watchdog.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [KEY_W-1:0]  key,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [1:0]        owner,
    output logic [KEY_W-1:0]  key_q,
    output logic              init_start,
    output logic              shuf_start,
    output logic              prga_start,
    input  logic              init_finish,
    input  logic              shuf_finish,
    input  logic              prga_finish,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] shuf_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] shuf_data,
    input  logic [DATA_W-1:0] prga_data,
    input  logic              init_wren,
    input  logic              shuf_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren
);

    localparam int CNT_W = $clog2(TIMEOUT);

    sched_state_t state;
    sched_state_t nxt_q;
    owner_t       own_q;
    logic         in_phase;
    logic         expired;

    assign in_phase = (state == ST_INIT) || (state == ST_SHUF) || (state == ST_PRGA);

    // Counter is held at zero outside phase states, so every phase entry starts fresh.
    phase_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_phase),
        .en       (in_phase),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            nxt_q      <= ST_SHUF;
            own_q      <= OWN_NONE;
            rdy        <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            key_q      <= '0;
            init_start <= 1'b0;
            shuf_start <= 1'b0;
            prga_start <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (en) begin
                        key_q      <= key;
                        err        <= 1'b0;
                        rdy        <= 1'b0;
                        own_q      <= OWN_INIT;
                        init_start <= 1'b1;
                        state      <= ST_INIT;
                    end
                end
                ST_INIT, ST_SHUF, ST_PRGA: begin
                    // A finish on the expiry edge still counts as a clean finish.
                    if ((state == ST_INIT && init_finish) ||
                        (state == ST_SHUF && shuf_finish) ||
                        (state == ST_PRGA && prga_finish)) begin
                        init_start <= 1'b0;
                        shuf_start <= 1'b0;
                        prga_start <= 1'b0;
                        own_q      <= OWN_NONE;
                        if (state == ST_PRGA) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            nxt_q <= (state == ST_INIT) ? ST_SHUF : ST_PRGA;
                            state <= ST_HANDOFF;
                        end
                    end else if (expired) begin
                        init_start <= 1'b0;
                        shuf_start <= 1'b0;
                        prga_start <= 1'b0;
                        own_q      <= OWN_NONE;
                        err        <= 1'b1;
                        state      <= ST_ERR;
                    end
                end
                ST_HANDOFF: begin
                    state      <= nxt_q;
                    own_q      <= owner_of(nxt_q);
                    shuf_start <= (nxt_q == ST_SHUF);
                    prga_start <= (nxt_q == ST_PRGA);
                end
                ST_DONE: begin
                    rdy   <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign owner = own_q;

    // Port mux follows the registered owner only, so a stray wren cannot leak through.
    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        case (own_q)
            OWN_INIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            OWN_SHUF: begin
                s_addr = shuf_addr;
                s_data = shuf_data;
                s_wren = shuf_wren;
            end
            OWN_PRGA: begin
                s_addr = prga_addr;
                s_data = prga_data;
                s_wren = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: a default-timeout and a TIMEOUT=16 instance share one
// stimulus stream and are each compared cycle by cycle against a phase model.
module tb_arc4_sched;

    localparam int TO_A = 4096;
    localparam int TO_B = 16;

    localparam int M_IDLE = 0;
    localparam int M_INIT = 1;
    localparam int M_SHUF = 2;
    localparam int M_PRGA = 3;
    localparam int M_GAP  = 4;
    localparam int M_DONE = 5;
    localparam int M_ERR  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [23:0] key = '0;
    logic        init_finish = 1'b0, shuf_finish = 1'b0, prga_finish = 1'b0;
    logic [7:0]  init_addr = '0, shuf_addr = '0, prga_addr = '0;
    logic [7:0]  init_data = '0, shuf_data = '0, prga_data = '0;
    logic        init_wren = 1'b0, shuf_wren = 1'b0, prga_wren = 1'b0;

    logic        rdy_o [2];
    logic        done_o [2];
    logic        err_o [2];
    logic [1:0]  owner_o [2];
    logic [23:0] keyq_o [2];
    logic        istart_o [2];
    logic        sstart_o [2];
    logic        pstart_o [2];
    logic [7:0]  saddr_o [2];
    logic [7:0]  sdata_o [2];
    logic        swren_o [2];

    always #5 clk = ~clk;

    arc4_sched u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .key(key),
        .rdy(rdy_o[0]), .done(done_o[0]), .err(err_o[0]), .owner(owner_o[0]), .key_q(keyq_o[0]),
        .init_start(istart_o[0]), .shuf_start(sstart_o[0]), .prga_start(pstart_o[0]),
        .init_finish(init_finish), .shuf_finish(shuf_finish), .prga_finish(prga_finish),
        .init_addr(init_addr), .shuf_addr(shuf_addr), .prga_addr(prga_addr),
        .init_data(init_data), .shuf_data(shuf_data), .prga_data(prga_data),
        .init_wren(init_wren), .shuf_wren(shuf_wren), .prga_wren(prga_wren),
        .s_addr(saddr_o[0]), .s_data(sdata_o[0]), .s_wren(swren_o[0])
    );

    arc4_sched #(.TIMEOUT(TO_B)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .key(key),
        .rdy(rdy_o[1]), .done(done_o[1]), .err(err_o[1]), .owner(owner_o[1]), .key_q(keyq_o[1]),
        .init_start(istart_o[1]), .shuf_start(sstart_o[1]), .prga_start(pstart_o[1]),
        .init_finish(init_finish), .shuf_finish(shuf_finish), .prga_finish(prga_finish),
        .init_addr(init_addr), .shuf_addr(shuf_addr), .prga_addr(prga_addr),
        .init_data(init_data), .shuf_data(shuf_data), .prga_data(prga_data),
        .init_wren(init_wren), .shuf_wren(shuf_wren), .prga_wren(prga_wren),
        .s_addr(saddr_o[1]), .s_data(sdata_o[1]), .s_wren(swren_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which phase each instance is in and how long it has been there.
    int          ph [2];
    int          age [2];
    int          nxt [2];
    logic [23:0] mkey [2];
    int          tmo [2] = '{TO_A, TO_B};

    int  dly [4];
    int  stub_ref = 0;
    bit  noise = 0;
    bit  en_rand = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = M_IDLE;
            age[d] = 0;
            nxt[d] = M_SHUF;
            mkey[d] = '0;
        end
    endtask

    function automatic bit fin_of(input int p);
        if (p == M_INIT) return init_finish;
        if (p == M_SHUF) return shuf_finish;
        return prga_finish;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (ph[d] == M_IDLE || ph[d] == M_ERR) begin
                if (en) begin
                    mkey[d] = key;
                    ph[d] = M_INIT;
                    age[d] = 0;
                end
            end else if (ph[d] >= M_INIT && ph[d] <= M_PRGA) begin
                if (fin_of(ph[d])) begin
                    if (ph[d] == M_PRGA) ph[d] = M_DONE;
                    else begin
                        nxt[d] = ph[d] + 1;
                        ph[d] = M_GAP;
                    end
                end else if (age[d] == tmo[d] - 1) begin
                    ph[d] = M_ERR;
                end else begin
                    age[d]++;
                end
            end else if (ph[d] == M_GAP) begin
                ph[d] = nxt[d];
                age[d] = 0;
            end else begin
                ph[d] = M_IDLE;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            string p;
            int own;
            logic [7:0] ea, ed;
            logic ew;
            p = (d == 0) ? "a." : "b.";
            own = (ph[d] >= M_INIT && ph[d] <= M_PRGA) ? ph[d] : 0;
            ea = '0; ed = '0; ew = 1'b0;
            if (own == 1) begin ea = init_addr; ed = init_data; ew = init_wren; end
            if (own == 2) begin ea = shuf_addr; ed = shuf_data; ew = shuf_wren; end
            if (own == 3) begin ea = prga_addr; ed = prga_data; ew = prga_wren; end
            chk({p, "rdy"},    32'(rdy_o[d]),    32'(ph[d] == M_IDLE));
            chk({p, "done"},   32'(done_o[d]),   32'(ph[d] == M_DONE));
            chk({p, "err"},    32'(err_o[d]),    32'(ph[d] == M_ERR));
            chk({p, "owner"},  32'(owner_o[d]),  32'(own));
            chk({p, "key_q"},  32'(keyq_o[d]),   32'(mkey[d]));
            chk({p, "istart"}, 32'(istart_o[d]), 32'(own == 1));
            chk({p, "sstart"}, 32'(sstart_o[d]), 32'(own == 2));
            chk({p, "pstart"}, 32'(pstart_o[d]), 32'(own == 3));
            chk({p, "s_addr"}, 32'(saddr_o[d]),  32'(ea));
            chk({p, "s_data"}, 32'(sdata_o[d]),  32'(ed));
            chk({p, "s_wren"}, 32'(swren_o[d]),  32'(ew));
        end
    endtask

    task automatic drive_inputs();
        int r, p;
        init_addr = 8'($urandom); shuf_addr = 8'($urandom); prga_addr = 8'($urandom);
        init_data = 8'($urandom); shuf_data = 8'($urandom); prga_data = 8'($urandom);
        init_wren = 1'($urandom); shuf_wren = 1'($urandom); prga_wren = 1'($urandom);
        r = stub_ref;
        p = ph[r];
        init_finish = (p == M_INIT) && dly[1] > 0 && age[r] == dly[1] - 1;
        shuf_finish = (p == M_SHUF) && dly[2] > 0 && age[r] == dly[2] - 1;
        prga_finish = (p == M_PRGA) && dly[3] > 0 && age[r] == dly[3] - 1;
        if (noise && $urandom_range(0, 7) == 0) begin
            init_finish = init_finish | 1'($urandom);
            shuf_finish = shuf_finish | 1'($urandom);
            prga_finish = prga_finish | 1'($urandom);
        end
        if (en_rand) begin
            en = ($urandom_range(0, 24) == 0);
            key = 24'($urandom);
        end else begin
            en = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        drive_inputs();
    endtask

    task automatic start_run(input logic [23:0] k);
        en = 1'b1;
        key = k;
        cycle();
    endtask

    initial begin
        int n, done_cnt, t0, cyc;
        bit seen_err, prev_s, prev_e;

        // Asynchronous reset mid-cycle; outputs must settle without a clock edge.
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs();

        // Directed full run with long phases and an ignored en during PRGA.
        stub_ref = 0; noise = 0; en_rand = 0;
        dly = '{0, 256, 768, 1024};
        start_run(24'h000249);
        done_cnt = 0;
        n = 0;
        while (ph[0] != M_IDLE && n < 3000) begin
            if (ph[0] == M_SHUF && age[0] == 10) begin
                init_wren = 1'b1; prga_wren = 1'b1; shuf_wren = 1'b0;
                #1 chk("shuf_foreign_wren", 32'(swren_o[0]), 32'd0);
                shuf_addr = 8'h5A; shuf_wren = 1'b1;
                #1 chk("shuf_addr", 32'(saddr_o[0]), 32'h5A);
                chk("shuf_wren", 32'(swren_o[0]), 32'd1);
            end
            if (ph[0] == M_PRGA && age[0] == 100) begin
                en = 1'b1;
                key = 24'hFFFFFF;
            end
            cycle();
            if (done_o[0]) done_cnt++;
            n++;
        end
        chk("run1_bounded", 32'(ph[0] == M_IDLE), 32'd1);
        chk("run1_done_cnt", 32'(done_cnt), 32'd1);
        chk("run1_key_q", 32'(keyq_o[0]), 32'h000249);

        // Shuffle stub never finishes: both instances must time out.
        dly = '{0, 5, 0, 0};
        start_run(24'h123456);
        n = 0; cyc = 0; t0 = 0; prev_s = 0; prev_e = 0;
        while (ph[0] != M_ERR && n < 6000) begin
            cycle();
            cyc++;
            if (sstart_o[1] && !prev_s) t0 = cyc;
            if (err_o[1] && !prev_e) chk("b_timeout_len", 32'(cyc - t0), 32'd16);
            prev_s = sstart_o[1];
            prev_e = err_o[1];
            n++;
        end
        chk("timeout_bounded", 32'(ph[0] == M_ERR), 32'd1);
        chk("a_err_held", 32'(err_o[0]), 32'd1);
        dly = '{0, 3, 3, 3};
        start_run(24'hABCDEF);
        chk("restart_err_clr", 32'(err_o[0]), 32'd0);
        n = 0;
        while (ph[0] != M_IDLE && n < 100) begin cycle(); n++; end
        chk("restart_bounded", 32'(ph[0] == M_IDLE), 32'd1);

        // Finish lands on the exact expiry edge of the TIMEOUT=16 instance.
        stub_ref = 1;
        dly = '{0, 16, 4, 4};
        start_run(24'h0F0F0F);
        seen_err = 0;
        n = 0;
        while (ph[1] != M_IDLE && n < 200) begin
            cycle();
            if (err_o[1]) seen_err = 1;
            n++;
        end
        chk("tie_no_err", 32'(seen_err), 32'd0);
        chk("tie_bounded", 32'(ph[1] == M_IDLE), 32'd1);

        // Reset dropped in the middle of a shuffle.
        stub_ref = 0;
        dly = '{0, 30, 30, 30};
        start_run(24'h5A5A5A);
        n = 0;
        while (!(ph[0] == M_SHUF && age[0] == 5) && n < 200) begin cycle(); n++; end
        chk("midreset_reach", 32'(ph[0] == M_SHUF), 32'd1);
        shuf_wren = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        chk("midreset_owner", 32'(owner_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs();

        // Randomised runs with stray finishes and en pulses.
        noise = 1;
        for (int run = 0; run < 20; run++) begin
            stub_ref = $urandom_range(0, 1);
            dly = '{0, $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40)};
            en_rand = 1;
            for (int c = 0; c < 300; c++) cycle();
            en_rand = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
